// File: rtl/uart_debug_pkg.sv
// uart_debug_pkg: shared opcodes, frame lengths, FSM state type and baud helper for the UART debug initiator
package uart_debug_pkg;
  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ = 8'h02;
  localparam int WR_LEN = 9;
  localparam int RD_LEN = 5;
  localparam int RSP_LEN = 4;
  typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP, DONE} state_t;
  function automatic int baud_div(input int clk_mhz, input int baud);
    return clk_mhz * 1000000 / baud;
  endfunction
endpackage

// File: rtl/uart_debug_initiator_if.sv
// uart_debug_initiator_if: command/response bundle between a command source (master) and the initiator (slave)
//   cmd_valid/cmd_ready handshake with cmd_write, cmd_addr, cmd_wdata
//   rsp_valid pulse with rsp_rdata, rsp_timeout; busy spans acceptance..rsp_valid
interface uart_debug_initiator_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_timeout;
  logic        busy;
  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_timeout, busy
  );
  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_timeout, busy
  );
endinterface

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 receiver with 2-flop synchronizer, start validation at DIV/2 and stop-bit framing check
//   clk, rst_n  : clock, asynchronous active-low reset
//   rxd         : asynchronous UART line, idle high
//   byte_valid  : one-cycle pulse on the stop-bit sample of a well-framed byte
//   byte_data   : received byte, valid with byte_valid
module uart_rx_byte #(
  parameter int DIV = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic       byte_valid,
  output logic [7:0] byte_data
);
  localparam int CW = $clog2(DIV) + 1;
  logic [1:0]    sync;
  logic          rxs;
  logic          prev;
  logic          active;
  logic [CW-1:0] ctr;
  logic [3:0]    bit_n;
  logic [7:0]    sh;
  logic          tick;
  assign rxs = sync[1];
  // first sample lands mid start bit, then every DIV cycles mid data/stop bit
  assign tick = active && ctr == (bit_n == 4'd0 ? CW'(DIV / 2 - 1) : CW'(DIV - 1));
  // combinational so the initiator can register completion on the sample edge itself
  assign byte_valid = tick && bit_n == 4'd9 && rxs;
  assign byte_data = sh;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 2'b11;
      prev <= 1'b1;
      active <= 1'b0;
      ctr <= '0;
      bit_n <= '0;
      sh <= '0;
    end else begin
      sync <= {sync[0], rxd};
      prev <= rxs;
      if (!active) begin
        if (prev && !rxs) begin
          active <= 1'b1;
          ctr <= '0;
          bit_n <= '0;
        end
      end else if (tick) begin
        ctr <= '0;
        bit_n <= bit_n + 1'b1;
        if (bit_n == 4'd0 && rxs) active <= 1'b0;
        if (bit_n != 4'd0 && bit_n != 4'd9) sh <= {rxs, sh[7:1]};
        if (bit_n == 4'd9) active <= 1'b0;
      end else begin
        ctr <= ctr + 1'b1;
      end
    end
  end
endmodule

// File: rtl/uart_debug_initiator.sv
// uart_debug_initiator: serializes 32-bit write/read commands as 8N1 UART frames and collects 4-byte read replies
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of uart_debug_initiator_if (command in, response out, busy)
//   txd        : UART transmit line, idle high
//   rxd        : UART receive line, idle high
//   Optional UART_INIT_TIMEOUT_EN: read-response timeout after TIMEOUT_CYCLES idle cycles in WAIT_RSP
module uart_debug_initiator
  import uart_debug_pkg::*;
#(
  parameter int CLK_FREQ_MHZ = 50,
  parameter int BAUD_RATE = 115200,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic clk,
  input  logic rst_n,
  uart_debug_initiator_if.slave bus,
  output logic txd,
  input  logic rxd
);
  localparam int DIV = baud_div(CLK_FREQ_MHZ, BAUD_RATE);
  localparam int BW = $clog2(DIV) + 1;
  state_t        state;
  logic [71:0]   frame;
  logic          is_write;
  logic [3:0]    cnt;
  logic [3:0]    bit_n;
  logic [BW-1:0] baud;
  logic [31:0]   rx_data;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          tmo_hit;
  uart_rx_byte #(.DIV(DIV)) u_rx (
    .clk(clk),
    .rst_n(rst_n),
    .rxd(rxd),
    .byte_valid(byte_valid),
    .byte_data(byte_data)
  );
`ifdef UART_INIT_TIMEOUT_EN
  logic [31:0] tmo;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo <= '0;
    else tmo <= (state != WAIT_RSP || byte_valid) ? '0 : tmo + 1'b1;
  end
  assign tmo_hit = state == WAIT_RSP && tmo == 32'(TIMEOUT_CYCLES - 1);
`else
  // no counter: always false for any legal TIMEOUT_CYCLES
  assign tmo_hit = TIMEOUT_CYCLES < 0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      txd <= 1'b1;
      bus.cmd_ready <= 1'b1;
      bus.busy <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_timeout <= 1'b0;
      bus.rsp_rdata <= '0;
      frame <= '0;
      is_write <= 1'b0;
      cnt <= '0;
      bit_n <= '0;
      baud <= '0;
      rx_data <= '0;
    end else begin
      unique case (state)
        IDLE: if (bus.cmd_valid) begin
          state <= SEND;
          bus.cmd_ready <= 1'b0;
          bus.busy <= 1'b1;
          is_write <= bus.cmd_write;
          frame <= {bus.cmd_wdata, bus.cmd_addr, bus.cmd_write ? CMD_WRITE : CMD_READ};
          cnt <= '0;
          bit_n <= '0;
          baud <= '0;
          txd <= 1'b0;
        end
        SEND: if (baud == BW'(DIV - 1)) begin
          baud <= '0;
          if (bit_n == 4'd9) begin
            if (cnt == (is_write ? 4'(WR_LEN - 1) : 4'(RD_LEN - 1))) begin
              txd <= 1'b1;
              cnt <= '0;
              rx_data <= '0;
              state <= is_write ? DONE : WAIT_RSP;
              bus.busy <= !is_write;
              bus.rsp_valid <= is_write;
            end else begin
              cnt <= cnt + 1'b1;
              bit_n <= '0;
              txd <= 1'b0;
              frame <= frame >> 8;
            end
          end else begin
            bit_n <= bit_n + 1'b1;
            // next bit is data bit bit_n, or the stop bit after bit 7
            txd <= bit_n == 4'd8 ? 1'b1 : frame[bit_n[2:0]];
          end
        end else begin
          baud <= baud + 1'b1;
        end
        WAIT_RSP: if (byte_valid) begin
          rx_data[{cnt[1:0], 3'b000} +: 8] <= byte_data;
          cnt <= cnt + 1'b1;
          if (cnt == 4'(RSP_LEN - 1)) begin
            state <= DONE;
            bus.busy <= 1'b0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_rdata <= {byte_data, rx_data[23:0]};
          end
        end else if (tmo_hit) begin
          state <= DONE;
          bus.busy <= 1'b0;
          bus.rsp_valid <= 1'b1;
          bus.rsp_timeout <= 1'b1;
          bus.rsp_rdata <= rx_data;
        end
        DONE: begin
          state <= IDLE;
          bus.rsp_valid <= 1'b0;
          bus.rsp_timeout <= 1'b0;
          bus.cmd_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
